// File: rtl/acc16_unit.sv
// ============================================================================
//  Module   : acc16_unit
//  Brief    : 16-bit accumulator built on one shared 8-bit add slice; ADD/SUB
//             take a low-byte cycle and a high-byte cycle, then commit atomically.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc16_unit #(
    parameter logic [15:0] ACC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op,
    input  logic [15:0] operand,
    output logic [15:0] acc,
    output logic        carry,
    output logic        zero,
    output logic        ovf,
    output logic        res_valid
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LO   = 2'd1;
    localparam logic [1:0] c_ST_HI   = 2'd2;

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_ADD  = 2'b01;
    localparam logic [1:0] c_OP_SUB  = 2'b10;
    localparam logic [1:0] c_OP_CLR  = 2'b11;

    logic [1:0]  r_state;
    logic [15:0] r_acc;
    logic        r_carry;
    logic        r_zero;
    logic        r_ovf;
    logic        r_res_valid;
    logic [15:0] r_b;
    logic        r_cin;
    logic [7:0]  r_lo;
    logic        r_tc;

    logic        w_accept;
    logic [7:0]  w_sl_a;
    logic [7:0]  w_sl_b;
    logic        w_sl_cin;
    logic [8:0]  w_sl_sum;
    logic [15:0] w_result;

    assign op_ready = (r_state == c_ST_IDLE) && rst_n;
    assign w_accept = op_valid && op_ready;

    // One byte slice serves both halves; the state picks which byte it sees.
    always_comb begin
        w_sl_a   = r_acc[7:0];
        w_sl_b   = r_b[7:0];
        w_sl_cin = r_cin;
        if (r_state == c_ST_HI) begin
            w_sl_a   = r_acc[15:8];
            w_sl_b   = r_b[15:8];
            w_sl_cin = r_tc;
        end
        w_sl_sum = {1'b0, w_sl_a} + {1'b0, w_sl_b} + {8'd0, w_sl_cin};
        w_result = {w_sl_sum[7:0], r_lo};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_acc       <= ACC_RESET;
            r_carry     <= 1'b0;
            r_zero      <= (ACC_RESET == 16'h0000);
            r_ovf       <= 1'b0;
            r_res_valid <= 1'b0;
            r_b         <= 16'h0000;
            r_cin       <= 1'b0;
            r_lo        <= 8'h00;
            r_tc        <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            c_OP_LOAD: begin
                                r_acc       <= operand;
                                r_carry     <= 1'b0;
                                r_ovf       <= 1'b0;
                                r_zero      <= (operand == 16'h0000);
                                r_res_valid <= 1'b1;
                            end
                            c_OP_CLR: begin
                                r_acc       <= 16'h0000;
                                r_carry     <= 1'b0;
                                r_ovf       <= 1'b0;
                                r_zero      <= 1'b1;
                                r_res_valid <= 1'b1;
                            end
                            c_OP_ADD: begin
                                r_b     <= operand;
                                r_cin   <= 1'b0;
                                r_state <= c_ST_LO;
                            end
                            c_OP_SUB: begin
                                r_b     <= ~operand;
                                r_cin   <= 1'b1;
                                r_state <= c_ST_LO;
                            end
                            default: r_state <= c_ST_IDLE;
                        endcase
                    end
                end
                c_ST_LO: begin
                    r_lo    <= w_sl_sum[7:0];
                    r_tc    <= w_sl_sum[8];
                    r_state <= c_ST_HI;
                end
                c_ST_HI: begin
                    // r_b already holds the inverted operand for SUB, so one ovf rule covers both.
                    r_acc       <= w_result;
                    r_carry     <= w_sl_sum[8];
                    r_ovf       <= (r_acc[15] == r_b[15]) && (w_result[15] != r_acc[15]);
                    r_zero      <= (w_result == 16'h0000);
                    r_res_valid <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign acc       = r_acc;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign res_valid = r_res_valid;

endmodule

`default_nettype wire
